apb_cmd_master: RTL and testbench

- APB requester (initiator). Converts a simple valid/ready command stream into single APB transfers and returns each result on a valid/ready response stream.
- Sits between a local controller (DMA, debug module, config sequencer) and an APB slave fabric of read-only or read-write register blocks.
- Optional access timeout guarantees forward progress if a slave never asserts pready.

---
 rtl/apb_cmd_master.sv | 178 +++++++++++++++++
 tb/tb_apb_cmd_master.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// APB command master: turns a valid/ready command stream into single APB
// transfers and returns each result on a valid/ready response stream.
// An optional ACCESS-phase timeout guarantees forward progress when a slave
// never asserts pready.

package apb_pkg;
    typedef logic [2:0] prot_t;
endpackage

module apb_cmd_master #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned StrbWidth     = DataWidth / 8,
    parameter int unsigned TimeoutCycles = 0
) (
    input  logic                 pclk_i,
    input  logic                 preset_ni,
    // command stream
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 req_write_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [StrbWidth-1:0] req_strb_i,
    input  apb_pkg::prot_t       req_prot_i,
    // response stream
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 rsp_timeout_o,
    // APB requester side
    output logic [AddrWidth-1:0] paddr_o,
    output logic [2:0]           pprot_o,
    output logic                 psel_o,
    output logic                 penable_o,
    output logic                 pwrite_o,
    output logic [DataWidth-1:0] pwdata_o,
    output logic [StrbWidth-1:0] pstrb_o,
    input  logic                 pready_i,
    input  logic [DataWidth-1:0] prdata_i,
    input  logic                 pslverr_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Counter only needs to reach TimeoutCycles-1 before the abort fires.
    localparam bit          TimeoutEn = (TimeoutCycles > 0);
    localparam int unsigned CntWidth  = TimeoutEn ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutEn ? TimeoutCycles - 1 : 0);
    localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

    state_e                state_q,   state_d;
    logic [AddrWidth-1:0]  paddr_q,   paddr_d;
    logic                  pwrite_q,  pwrite_d;
    logic [DataWidth-1:0]  pwdata_q,  pwdata_d;
    logic [StrbWidth-1:0]  pstrb_q,   pstrb_d;
    apb_pkg::prot_t        pprot_q,   pprot_d;
    logic [DataWidth-1:0]  rdata_q,   rdata_d;
    logic                  err_q,     err_d;
    logic                  timeout_q, timeout_d;
    logic [CntWidth-1:0]   cnt_q,     cnt_d;

    // Handshake and APB phase signals decode directly from the state flop,
    // so an asynchronous reset drops psel/penable/rsp_valid immediately.
    assign req_ready_o   = (state_q == IDLE);
    assign psel_o        = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o     = (state_q == ACCESS);
    assign rsp_valid_o   = (state_q == RESP);

    assign paddr_o       = paddr_q;
    assign pprot_o       = pprot_q;
    assign pwrite_o      = pwrite_q;
    assign pwdata_o      = pwdata_q;
    assign pstrb_o       = pstrb_q;
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = timeout_q;

    // Next-state and datapath capture for the IDLE/SETUP/ACCESS/RESP sequence.
    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        pprot_d   = pprot_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    paddr_d  = req_addr_i;
                    pwrite_d = req_write_i;
                    pwdata_d = req_wdata_i;
                    // Reads never present strobes on the bus.
                    pstrb_d  = req_write_i ? req_strb_i : {StrbWidth{1'b0}};
                    pprot_d  = req_prot_i;
                    state_d  = SETUP;
                end else begin
                    state_d  = IDLE;
                end
            end

            SETUP: begin
                cnt_d   = {CntWidth{1'b0}};
                state_d = ACCESS;
            end

            ACCESS: begin
                if (pready_i) begin
                    // Completion beats a timeout that would fire in the same cycle.
                    rdata_d   = pwrite_q ? {DataWidth{1'b0}} : prdata_i;
                    err_d     = pslverr_i;
                    timeout_d = 1'b0;
                    state_d   = RESP;
                end else if (TimeoutEn && (cnt_q == CntLast)) begin
                    rdata_d   = {DataWidth{1'b0}};
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else if (TimeoutEn) begin
                    cnt_d     = cnt_q + CntOne;
                end else begin
                    cnt_d     = cnt_q;
                end
            end

            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-field registers with asynchronous active-low reset.
    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            state_q   <= IDLE;
            paddr_q   <= {AddrWidth{1'b0}};
            pwrite_q  <= 1'b0;
            pwdata_q  <= {DataWidth{1'b0}};
            pstrb_q   <= {StrbWidth{1'b0}};
            pprot_q   <= 3'b000;
            rdata_q   <= {DataWidth{1'b0}};
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= {CntWidth{1'b0}};
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            pprot_q   <= pprot_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a 4-cycle access timeout.
// Inputs are driven and outputs sampled on the falling clock edge.
`timescale 1ns/1ps

module tb_apb_cmd_master;

    logic        pclk;
    logic        preset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int total = 0;
    int bad   = 0;

    apb_cmd_master #(
        .AddrWidth     (32),
        .DataWidth     (32),
        .TimeoutCycles (4)
    ) dut (
        .pclk_i        (pclk),
        .preset_ni     (preset_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .req_write_i   (req_write),
        .req_wdata_i   (req_wdata),
        .req_strb_i    (req_strb),
        .req_prot_i    (req_prot),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .rsp_timeout_o (rsp_timeout),
        .paddr_o       (paddr),
        .pprot_o       (pprot),
        .psel_o        (psel),
        .penable_o     (penable),
        .pwrite_o      (pwrite),
        .pwdata_o      (pwdata),
        .pstrb_o       (pstrb),
        .pready_i      (pready),
        .prdata_i      (prdata),
        .pslverr_i     (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Watchdog in case the bench itself stalls.
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic drive_cmd(input logic [31:0] a, input logic w, input logic [31:0] d,
                             input logic [3:0] s, input logic [2:0] p);
        req_valid = 1'b1;
        req_addr  = a;
        req_write = w;
        req_wdata = d;
        req_strb  = s;
        req_prot  = p;
    endtask

    task automatic test_reset();
        preset_n = 1'b0;
        @(negedge pclk);
        total++;
        if ({psel, penable, rsp_valid, req_ready} !== 4'b0001) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=0001", {psel, penable, rsp_valid, req_ready});
        end
        total++;
        if ({paddr, pwdata, pstrb, pwrite, pprot} !== 72'd0) begin
            bad++; $display("FAIL reset_apb got addr=%h wdata=%h strb=%h wr=%b prot=%h exp all 0", paddr, pwdata, pstrb, pwrite, pprot);
        end
        total++;
        if ({rsp_rdata, rsp_err, rsp_timeout} !== 34'd0) begin
            bad++; $display("FAIL reset_rsp got rdata=%h err=%b to=%b exp 0", rsp_rdata, rsp_err, rsp_timeout);
        end
        preset_n = 1'b1;
        @(negedge pclk);
    endtask

    task automatic test_read_zero_wait();
        @(negedge pclk);
        drive_cmd(32'h0000_0008, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b010);
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL rd_accept req_ready got=%b exp=1", req_ready);
        end
        @(negedge pclk); // N+1: SETUP
        req_valid = 1'b0;
        total++;
        if ({psel, penable, rsp_valid} !== 3'b100) begin
            bad++; $display("FAIL rd_setup sel/en/rv got=%b exp=100", {psel, penable, rsp_valid});
        end
        total++;
        if (paddr !== 32'h8 || pstrb !== 4'h0 || pwrite !== 1'b0 || pprot !== 3'b010) begin
            bad++; $display("FAIL rd_setup_bus got addr=%h strb=%h wr=%b prot=%h exp 8/0/0/2", paddr, pstrb, pwrite, pprot);
        end
        @(negedge pclk); // N+2: ACCESS
        total++;
        if ({psel, penable, pstrb} !== 6'b110000) begin
            bad++; $display("FAIL rd_access got sel/en=%b strb=%h exp 11/0", {psel, penable}, pstrb);
        end
        pready = 1'b1;
        prdata = 32'hCAFE_F00D;
        @(negedge pclk); // N+3: RESP
        pready = 1'b0;
        prdata = 32'h0;
        total++;
        if ({rsp_valid, rsp_err, rsp_timeout, psel, penable, req_ready} !== 6'b100000 || rsp_rdata !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL rd_resp got v/e/t/sel/en/rdy=%b rdata=%h exp 100000 cafef00d", {rsp_valid, rsp_err, rsp_timeout, psel, penable, req_ready}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        total++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            bad++; $display("FAIL rd_done rv/rdy got=%b exp=01", {rsp_valid, req_ready});
        end
    endtask

    task automatic test_write_waits();
        @(negedge pclk);
        drive_cmd(32'h0000_0010, 1'b1, 32'h1234_5678, 4'hF, 3'b001);
        @(negedge pclk); // SETUP; scramble the source to prove the bus is held
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_0000;
        req_wdata = 32'h0;
        req_write = 1'b0;
        total++;
        if ({psel, penable} !== 2'b10) begin
            bad++; $display("FAIL wr_setup sel/en got=%b exp=10", {psel, penable});
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge pclk);
            total++;
            if ({psel, penable, pwrite} !== 3'b111 || paddr !== 32'h10 || pwdata !== 32'h1234_5678 || pstrb !== 4'hF) begin
                bad++; $display("FAIL wr_access_%0d got sel/en/wr=%b addr=%h wdata=%h strb=%h", k, {psel, penable, pwrite}, paddr, pwdata, pstrb);
            end
            pready = (k == 4);
            prdata = 32'hDEAD_BEEF;
        end
        @(negedge pclk);
        pready = 1'b0;
        total++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100 || rsp_rdata !== 32'h0) begin
            bad++; $display("FAIL wr_resp got v/e/t=%b rdata=%h exp 100 00000000", {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_slave_error();
        @(negedge pclk);
        drive_cmd(32'h0000_0020, 1'b0, 32'h0, 4'h0, 3'b000);
        @(negedge pclk); // SETUP
        req_valid = 1'b0;
        @(negedge pclk); // ACCESS
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'h55AA_55AA;
        @(negedge pclk);
        pready  = 1'b0;
        pslverr = 1'b0;
        total++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110 || rsp_rdata !== 32'h55AA_55AA) begin
            bad++; $display("FAIL slverr got v/e/t=%b rdata=%h exp 110 55aa55aa", {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout(input logic ready_on_4th);
        @(negedge pclk);
        drive_cmd(32'h0000_0030, 1'b0, 32'h0, 4'h0, 3'b000);
        @(negedge pclk); // SETUP
        req_valid = 1'b0;
        prdata    = 32'h0BAD_CAFE;
        for (int k = 1; k <= 4; k++) begin
            @(negedge pclk);
            total++;
            if ({psel, penable, rsp_valid} !== 3'b110) begin
                bad++; $display("FAIL to_access_%0d rdy4=%b got sel/en/rv=%b exp=110", k, ready_on_4th, {psel, penable, rsp_valid});
            end
            pready = ready_on_4th && (k == 4);
        end
        @(negedge pclk);
        pready = 1'b0;
        if (ready_on_4th) begin
            total++;
            if ({psel, penable, rsp_valid, rsp_err, rsp_timeout} !== 5'b00100 || rsp_rdata !== 32'h0BAD_CAFE) begin
                bad++; $display("FAIL to_edge got sel/en/v/e/t=%b rdata=%h exp 00100 0badcafe", {psel, penable, rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
            end
        end else begin
            total++;
            if ({psel, penable, rsp_valid, rsp_err, rsp_timeout} !== 5'b00111 || rsp_rdata !== 32'h0) begin
                bad++; $display("FAIL to_abort got sel/en/v/e/t=%b rdata=%h exp 00111 00000000", {psel, penable, rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
            end
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        prdata    = 32'h0;
    endtask

    task automatic test_backpressure();
        @(negedge pclk);
        drive_cmd(32'h0000_0040, 1'b0, 32'h0, 4'h0, 3'b000);
        @(negedge pclk); // SETUP
        req_valid = 1'b0;
        @(negedge pclk); // ACCESS
        pready = 1'b1;
        prdata = 32'h1111_2222;
        @(negedge pclk); // RESP
        pready = 1'b0;
        prdata = 32'h0;
        drive_cmd(32'h0000_0044, 1'b1, 32'hA5A5_A5A5, 4'h3, 3'b100);
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({rsp_valid, req_ready, psel, rsp_err, rsp_timeout} !== 5'b10000 || rsp_rdata !== 32'h1111_2222) begin
                bad++; $display("FAIL bp_hold_%0d got v/rdy/sel/e/t=%b rdata=%h exp 10000 11112222", k, {rsp_valid, req_ready, psel, rsp_err, rsp_timeout}, rsp_rdata);
            end
            @(negedge pclk);
        end
        rsp_ready = 1'b1;
        @(negedge pclk); // back in IDLE, held command taken this cycle
        rsp_ready = 1'b0;
        total++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            bad++; $display("FAIL bp_accept rv/rdy got=%b exp=01", {rsp_valid, req_ready});
        end
        @(negedge pclk); // SETUP of second command
        req_valid = 1'b0;
        total++;
        if ({psel, penable, pwrite} !== 3'b101 || paddr !== 32'h44 || pwdata !== 32'hA5A5_A5A5 || pstrb !== 4'h3 || pprot !== 3'b100) begin
            bad++; $display("FAIL bp_next_setup got sel/en/wr=%b addr=%h wdata=%h strb=%h prot=%h", {psel, penable, pwrite}, paddr, pwdata, pstrb, pprot);
        end
        @(negedge pclk); // ACCESS
        pready = 1'b1;
        @(negedge pclk);
        pready = 1'b0;
        total++;
        if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0) begin
            bad++; $display("FAIL bp_next_resp got v/e=%b rdata=%h exp 10 00000000", {rsp_valid, rsp_err}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_in_access();
        @(negedge pclk);
        drive_cmd(32'h0000_0050, 1'b0, 32'h0, 4'h0, 3'b000);
        @(negedge pclk); // SETUP
        req_valid = 1'b0;
        @(negedge pclk); // ACCESS 1
        @(negedge pclk); // ACCESS 2
        total++;
        if ({psel, penable} !== 2'b11) begin
            bad++; $display("FAIL rst_pre sel/en got=%b exp=11", {psel, penable});
        end
        preset_n = 1'b0;
        #1;
        total++;
        if ({psel, penable, rsp_valid} !== 3'b000) begin
            bad++; $display("FAIL rst_async sel/en/rv got=%b exp=000", {psel, penable, rsp_valid});
        end
        @(negedge pclk);
        preset_n = 1'b1;
        @(negedge pclk);
        total++;
        if ({req_ready, psel, penable, rsp_valid} !== 4'b1000) begin
            bad++; $display("FAIL rst_idle rdy/sel/en/rv got=%b exp=1000", {req_ready, psel, penable, rsp_valid});
        end
        drive_cmd(32'h0000_0060, 1'b0, 32'h0, 4'hF, 3'b000);
        @(negedge pclk); // SETUP
        req_valid = 1'b0;
        @(negedge pclk); // ACCESS
        pready = 1'b1;
        prdata = 32'h600D_600D;
        @(negedge pclk);
        pready = 1'b0;
        prdata = 32'h0;
        total++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100 || rsp_rdata !== 32'h600D_600D) begin
            bad++; $display("FAIL rst_after_read got v/e/t=%b rdata=%h exp 100 600d600d", {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        preset_n  = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_write = 1'b0;
        req_wdata = 32'h0;
        req_strb  = 4'h0;
        req_prot  = 3'b000;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        prdata    = 32'h0;
        pslverr   = 1'b0;

        test_reset();
        test_read_zero_wait();
        test_write_waits();
        test_slave_error();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_backpressure();
        test_reset_in_access();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
